// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, with a start/busy/done handshake.
// Optional signed-overflow output is built only when SOMADOR_OVF_EN is defined.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SOMADOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             last_bit;
    logic [1:0]       fa;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign fa       = full_add(a_sh[0], b_sh[0], carry);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) state_n = DONE;
            end
            DONE: begin
                if (start) begin
                    state_n = SHIFT;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SOMADOR_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= fa[1];
                cnt   <= cnt + CNT_W'(1);
                res   <= {fa[0], res[WIDTH-1:1]};
                // Final bit: publish the completed word together with its carry-out.
                if (last_bit) begin
                    s    <= {fa[0], res[WIDTH-1:1]};
                    cout <= fa[1];
`ifdef SOMADOR_OVF_EN
                    ovf  <= carry ^ fa[1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial (WIDTH=8): cycle-level arithmetic reference model,
// per-cycle comparison, directed cases from the test plan and randomized operations.
module tb_somador_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
`ifdef SOMADOR_OVF_EN
    logic         ovf;
`endif

    int passed = 0;
    int total  = 0;

    somador_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef SOMADOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an accepted request completes WIDTH edges later with the plain arithmetic sum.
    int           rem = 0;
    logic [W:0]   pend = '0;
    logic         pend_ovf = 1'b0;
    logic [W-1:0] m_s = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            rem = 0; m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    {m_cout, m_s} = pend;
                    m_ovf  = pend_ovf;
                    m_done = 1'b1;
                end
            end else if (start) begin
                pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                pend_ovf = (a[W-1] == b[W-1]) && (pend[W-1] != a[W-1]);
                rem      = W;
            end
            m_busy = (rem > 0);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_s", 32'(s), 32'(m_s));
        chk("cyc_cout", 32'(cout), 32'(m_cout));
        chk("cyc_excl", 32'(busy & done), 32'd0);
`ifdef SOMADOR_OVF_EN
        chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic eo, input bit noise);
        int cyc;
        int bcnt;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            if (noise) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("op_done_seen", 32'(done), 32'd1);
        chk("op_s", 32'(s), 32'(es));
        chk("op_cout", 32'(cout), 32'(ec));
        chk("op_busy_cycles", 32'(bcnt), 32'(W));
`ifdef SOMADOR_OVF_EN
        chk("op_ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown overflow expectation");
`endif
        @(negedge clk);
        chk("op_done_single", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, ec, eo;
        int           dn;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            {ec, es} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
            op(ra, rb, rc, es, ec, eo, (i % 3) == 0);
        end

        // Start held high: results arrive every W+1 cycles.
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
        dn = 0;
        repeat (5 * (W + 1)) begin
            @(negedge clk);
            if (done) dn++;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(dn), 32'd5);
        repeat (W + 3) @(negedge clk);

        // Reset in the middle of an operation.
        op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. Successor to the 1-bit combinational full adder. Trades latency for area on wide operands and adds a start/busy/done handshake. It sits between a sequencing controller and a result register bank.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when s/cout are updated.
- s  output  WIDTH  registered sum, held until the next completion.
- cout  output  1  registered carry-out, held with s.
- ovf  output  1  signed overflow; present only with SOMADOR_OVF_EN.

## Operation
- FSM states:
  - IDLE: start=1 goes to SHIFT.
  - SHIFT: after WIDTH bit-cycles, goes to DONE.
  - DONE: start=1 goes to SHIFT; otherwise goes to IDLE.
- Start acceptance:
  - Latch a, b into internal shift registers.
  - Load the carry flop with cin.
  - Clear the bit counter to 0.
- Each SHIFT cycle:
  - Full adder on the LSBs of the shift registers and the carry flop.
  - Sum bit shifts into the MSB of the internal result register.
  - Carry flop updates.
  - Operand registers shift right.
  - Counter increments.
- On the final bit (counter = WIDTH-1):
  - Internal result plus this bit are copied to s.
  - The carry-out of this bit is copied to cout.
  - The state moves to DONE.
- Result definition:
  - s = (a + b + cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full (WIDTH+1)-bit sum.
- Inputs are ignored during SHIFT:
  - start is ignored.
  - Changes on a, b, cin are ignored.
- s and cout change only at a completion edge. Between completions they hold the previous result.
- Counter width: clog2(WIDTH)+1 bits; no wrap during normal operation.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal registers and counter are cleared.
  - Reset during SHIFT aborts the operation. No done is produced, and s/cout read 0.
- Latency:
  - Start accepted at edge E0.
  - busy=1 from E0 until edge E0+WIDTH.
  - s/cout update at edge E0+WIDTH, and done=1 for that one cycle.
  - Total latency is WIDTH+1 cycles from start sample to done visible.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge. busy rises the next cycle, with zero idle gap. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SOMADOR_OVF_EN defined:
  - Port ovf exists.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - ovf is registered and updated with s/cout, and held the same way.
  - Reset value is 0.
- SOMADOR_OVF_EN undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Wrap: a=8'hFF, b=8'h01, cin=0, start -> done after 9 cycles, s=8'h00, cout=1; busy high for exactly 8 cycles.
- Carry-in: a=8'h00, b=8'h00, cin=1 -> s=8'h01, cout=0. Then a=8'hA5, b=8'h5A, cin=1 -> s=8'h00, cout=1.
- Overflow (with SOMADOR_OVF_EN):
  - 8'h7F+8'h01, cin=0 -> s=8'h80, cout=0, ovf=1.
  - 8'h80+8'h80 -> s=8'h00, cout=1, ovf=1.
  - 8'hFF+8'h01 -> ovf=0.
- Ignored inputs: start pulses and a/b changes mid-SHIFT have no effect. Only one done appears, and the result matches the originally latched operands.
- Back-to-back: start held high continuously -> done pulses every 9 cycles, each with the operands present at that acceptance edge.
- Reset mid-op: assert rst at bit-cycle 4 -> busy, done, s, cout all 0 immediately. After release, a new start (8'h10+8'h20) gives s=8'h30, cout=0.
